// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, and
// presents buffered {pc, inst} pairs to decode. IF_PERF_CNT_EN adds perf counters.
module if_fetch #(
  parameter int                PC_W     = 12,
  parameter logic [PC_W-1:0]   RESET_PC = 12'h000,
  parameter int                DEPTH    = 2,
  parameter logic [31:0]       NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     inst_o,
  output logic            inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_bubble_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     q_cnt_q, q_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]   q_pc_q   [DEPTH];
  logic [31:0]       q_inst_q [DEPTH];
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;

  logic              issue;
  logic              push;
  logic              load;
  logic [PC_W-1:0]   redirect_pc;
  logic              unused_redirect_lsb;

  assign redirect_pc         = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // rst gates the request so nothing is issued while the stage is held in reset
  assign imem_req_o  = !rst && (state_q == RUN) && !flush_i &&
                       (({1'b0, out_q} + {1'b0, q_cnt_q}) < DEPTH_W);
  assign imem_addr_o = fetch_pc_q;
  assign issue       = imem_req_o && imem_gnt_i;
  assign push        = imem_rvalid_i && (state_q == RUN) && !flush_i;
  assign load        = !flush_i && (q_cnt_q != '0) && (!valid_q || !stall_i);

  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_cnt_d    = q_cnt_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    out_d      = out_q + CW'(issue) - CW'(imem_rvalid_i);

    if (flush_i || state_q == DRAIN) begin
      state_d = (out_d != '0) ? DRAIN : RUN;
    end

    if (flush_i) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      q_cnt_d    = '0;
      valid_d    = 1'b0;
      inst_d     = NOP_INST;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_W'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + PC_W'(4);
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (load) rd_ptr_d = rd_ptr_q + AW'(1);
      q_cnt_d = q_cnt_q + CW'(push) - CW'(load);

      if (load) begin
        pc_d    = q_pc_q[rd_ptr_q];
        inst_d  = q_inst_q[rd_ptr_q];
        valid_d = 1'b1;
      end else if (!stall_i) begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      q_cnt_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      q_cnt_q    <= q_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by q_cnt_q
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc_q[wr_ptr_q]   <= resp_pc_q;
      q_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && q_cnt_q == CW'(DEPTH)))
        else $error("if_fetch: push into full fetch queue");
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (load && perf_fetch_q != 32'hFFFF_FFFF)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (!valid_q && !stall_i && perf_bubble_q != 32'hFFFF_FFFF)
        perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a reference model of the fetch stage predicts every
// request and presented pair; a scoreboard queue holds fetched-but-unpresented words.
module tb_if_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, stall, flush;
  logic [11:0] redir;
  logic [31:0] rdata;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [11:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_bubble;
`endif

  always #5 clk = ~clk;

  if_fetch #(.PC_W(12), .RESET_PC(12'h000), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .stall_i(stall), .flush_i(flush), .redirect_pc_i(redir),
    .pc_o(pc_out), .inst_o(inst_out), .inst_valid_o(valid_out)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_o(perf_fetch), .perf_bubble_o(perf_bubble)
`endif
  );

  typedef struct { logic [11:0] pc; logic [31:0] inst; } ent_t;

  int vectors = 0, miscompares = 0;
  ent_t        sb[$];
  logic [11:0] pend[$];
  logic [11:0] m_fetch, m_resp, m_pc;
  logic [31:0] m_inst;
  logic        m_valid, m_drain;
  int          m_out, cyc, m_nfetch, m_nbubble;
  bit          mem_en;

  function automatic logic [31:0] tag(input logic [11:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic exp_req, ld;
    ent_t e;
    #3;
    exp_req = !m_drain && !flush && (m_out + sb.size() < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_fetch);
    if (!m_valid && !stall) m_nbubble++;
    if (flush) begin
      sb.delete();
      m_valid = 1'b0;
      m_inst  = NOP;
      m_fetch = {redir[11:2], 2'b00};
      m_resp  = {redir[11:2], 2'b00};
    end else begin
      ld = (sb.size() > 0) && (!m_valid || !stall);
      if (ld) begin
        e = sb.pop_front();
        m_pc = e.pc; m_inst = e.inst; m_valid = 1'b1;
        m_nfetch++;
      end else if (!stall) begin
        m_valid = 1'b0; m_inst = NOP;
      end
      if (!m_drain && rvalid) begin
        sb.push_back('{m_resp, tag(m_resp)});
        m_resp = m_resp + 12'd4;
      end
      if (exp_req && gnt) m_fetch = m_fetch + 12'd4;
    end
    m_out = m_out + int'(exp_req && gnt) - int'(rvalid);
    if (flush || m_drain) m_drain = (m_out > 0);
    if (imem_req && gnt) pend.push_back(imem_addr);
    @(posedge clk); #1;
    cyc++;
    check("inst_valid", valid_out, m_valid);
    check("pc_o", pc_out, m_pc);
    check("inst_o", inst_out, m_inst);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, m_nfetch);
    check("perf_bubble", perf_bubble, m_nbubble);
`endif
    rvalid = mem_en && (pend.size() > 0);
    rdata  = rvalid ? tag(pend.pop_front()) : 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; gnt = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; redir = 12'h0;
    pend.delete(); sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_inst", inst_out, NOP);
    check("rst_pc", pc_out, 12'h000);
    rst = 1'b0;
    m_fetch = 12'h000; m_resp = 12'h000; m_pc = 12'h000;
    m_inst = NOP; m_valid = 1'b0; m_drain = 1'b0; m_out = 0;
    cyc = 0; m_nfetch = 0; m_nbubble = 0;
  endtask

  initial begin
    int  first_valid, n;
    bit  found, saw_ffc, saw_wrap;

    // Streaming fetch from reset, 1-cycle memory
    mem_en = 1'b1;
    do_reset();
    gnt = 1'b1;
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (first_valid < 0 && valid_out) first_valid = cyc;
    end
    check("first_valid_cycle", first_valid, 3);

    // Grant withheld: credits drain, request held high, output empties
    gnt = 1'b0;
    repeat (6) tick();
    check("nogrant_req", imem_req, 1'b1);
    check("nogrant_valid", valid_out, 1'b0);
    check("nogrant_inst", inst_out, NOP);
    gnt = 1'b1;

    // Stall with pc_o=008 presented
    do_reset();
    gnt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = valid_out && (pc_out == 12'h008);
    end
    check("reach_pc008", found, 1'b1);
    stall = 1'b1;
    repeat (3) tick();
    check("stall_pc", pc_out, 12'h008);
    check("stall_inst", inst_out, tag(12'h008));
    check("stall_req_drop", imem_req, 1'b0);
    stall = 1'b0;
    tick();
    check("release_pc0", pc_out, 12'h00C);
    tick();
    check("release_pc1", pc_out, 12'h010);

    // Flush to 100 with two requests outstanding
    mem_en = 1'b0;
    for (int i = 0; i < 10 && m_out != 2; i++) tick();
    check("two_outstanding", m_out, 2);
    flush = 1'b1; redir = 12'h100;
    tick();
    flush = 1'b0;
    check("flush_valid", valid_out, 1'b0);
    check("drain_req", imem_req, 1'b0);
    mem_en = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    check("redirect_req", imem_req, 1'b1);
    check("redirect_addr", imem_addr, 12'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = valid_out && (pc_out == 12'h100);
    end
    check("present_pc100", found, 1'b1);

    // Flush beats stall; redirect low bits ignored; PC wraps past FFC
    found = valid_out;
    for (int i = 0; i < 10 && !found; i++) begin tick(); found = valid_out; end
    check("valid_before_flush", found, 1'b1);
    stall = 1'b1; flush = 1'b1; redir = 12'hFFA;
    tick();
    stall = 1'b0; flush = 1'b0;
    check("flush_over_stall", valid_out, 1'b0);
    saw_ffc = 1'b0; saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_out && pc_out == 12'hFFC) saw_ffc = 1'b1;
      if (saw_ffc && valid_out && pc_out == 12'h000) saw_wrap = 1'b1;
    end
    check("pc_wrap", saw_wrap, 1'b1);

    // Reset in the middle of traffic
    tick();
    do_reset();
    gnt = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
